// File: rtl/bist_misr_if.sv
// Control and data bundle between the BIST MISR controller and its environment.
// The master drives run requests and response data; the slave is the MISR.
interface bist_misr_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             Start;
    logic [WIDTH-1:0] Din;
    logic             Din_valid;
    logic [WIDTH-1:0] Golden;
    logic             Load;
    logic [WIDTH-1:0] Signature;
    logic             Busy;
    logic             Done;
    logic             Pass;

    modport master (
        output Start,
        output Din,
        output Din_valid,
        output Golden,
        input  Load,
        input  Signature,
        input  Busy,
        input  Done,
        input  Pass
    );

    modport slave (
        input  Start,
        input  Din,
        input  Din_valid,
        input  Golden,
        output Load,
        output Signature,
        output Busy,
        output Done,
        output Pass
    );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register with run controller. Pulses Load to the
// PRPG, compacts PATTERNS valid response words and compares against Golden.
module bist_misr #(
    parameter int unsigned           WIDTH    = 8,
    parameter logic [WIDTH-1:0]      POLY     = 8'h1D,
    parameter logic [WIDTH-1:0]      SEED     = '0,
    parameter int unsigned           PATTERNS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bist_misr_if.slave      bus
);

    localparam int unsigned CntW = $clog2(PATTERNS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StCompact,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sig_q, sig_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [WIDTH-1:0]  misr_next;

    // MISR step: shift left, fold MSB back through the tap mask, XOR in the response word
    always_comb begin
        misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ bus.Din;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A restart in DONE wins over any concurrent Din_valid
                if (bus.Start) begin
                    state_d = StSeed;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StSeed: begin
                state_d = StCompact;
            end
            StCompact: begin
                if (bus.Din_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (misr_next == bus.Golden);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.Load      = load_q;
    assign bus.Signature = sig_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Pass      = pass_q;

endmodule

// File: tb/tb_bist_misr.sv
// Directed bench for bist_misr with WIDTH=8, POLY=8'h1D, SEED=0, PATTERNS=4.
module tb_bist_misr;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   edges;

    logic [7:0] din_seq [4] = '{8'h80, 8'h00, 8'h00, 8'h00};
    logic [7:0] sig_seq [4] = '{8'h80, 8'h1D, 8'h3A, 8'h74};

    bist_misr_if #(.WIDTH(8)) bus ();

    bist_misr #(
        .WIDTH    (8),
        .POLY     (8'h1D),
        .SEED     (8'h00),
        .PATTERNS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed the four directed samples back to back, checking each signature step
    task automatic feed_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.Din       = din_seq[i];
            bus.Din_valid = 1'b1;
            tick();
            check({tag, "_sig"}, bus.Signature, sig_seq[i]);
            if (i < 3) check({tag, "_done_early"}, bus.Done, 1'b0);
        end
        bus.Din_valid = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b1;
        bus.Start     = 1'b0;
        bus.Din       = 8'h00;
        bus.Din_valid = 1'b0;
        bus.Golden    = 8'h00;

        // Reset asserted mid-clock must clear outputs without an edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_sig", bus.Signature, 8'h00);
        check("rst_load", bus.Load, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_done", bus.Done, 1'b0);
        check("rst_pass", bus.Pass, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("idle_hold_busy", bus.Busy, 1'b0);

        // Pass path
        bus.Golden = 8'h74;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        check("p_seed_load", bus.Load, 1'b1);
        check("p_seed_busy", bus.Busy, 1'b1);
        check("p_seed_sig", bus.Signature, 8'h00);
        bus.Din       = 8'h80;
        bus.Din_valid = 1'b1;
        tick();
        check("p_load_one_cycle", bus.Load, 1'b0);
        check("p_seed_ignores_valid", bus.Signature, 8'h00);
        check("p_compact_busy", bus.Busy, 1'b1);
        feed_all("p");
        check("p_done", bus.Done, 1'b1);
        check("p_pass", bus.Pass, 1'b1);
        check("p_busy_fall", bus.Busy, 1'b0);
        check("p_load_low", bus.Load, 1'b0);
        bus.Din       = 8'hFF;
        bus.Din_valid = 1'b1;
        tick();
        check("p_done_hold_sig", bus.Signature, 8'h74);
        check("p_done_hold_done", bus.Done, 1'b1);
        check("p_done_hold_pass", bus.Pass, 1'b1);

        // Fail path; restart from DONE with a concurrent valid sample
        bus.Golden    = 8'h75;
        bus.Start     = 1'b1;
        bus.Din       = 8'hFF;
        bus.Din_valid = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("f_restart_load", bus.Load, 1'b1);
        check("f_restart_done", bus.Done, 1'b0);
        check("f_restart_pass", bus.Pass, 1'b0);
        check("f_restart_sig", bus.Signature, 8'h00);
        tick();
        check("f_seed_ignores_valid", bus.Signature, 8'h00);
        feed_all("f");
        check("f_done", bus.Done, 1'b1);
        check("f_pass", bus.Pass, 1'b0);
        check("f_sig", bus.Signature, 8'h74);

        // Stall of 3 cycles between samples, with a Start pulse inside it
        bus.Golden    = 8'h74;
        bus.Din_valid = 1'b0;
        bus.Start     = 1'b1;
        tick();
        edges     = 0;
        bus.Start = 1'b0;
        tick();
        edges++;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.Din_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    bus.Start = (k == 1);
                    tick();
                    edges++;
                    check("s_stall_sig", bus.Signature, 8'h1D);
                    check("s_stall_load", bus.Load, 1'b0);
                    check("s_stall_busy", bus.Busy, 1'b1);
                end
                bus.Start = 1'b0;
            end
            bus.Din       = din_seq[i];
            bus.Din_valid = 1'b1;
            tick();
            edges++;
            check("s_sig", bus.Signature, sig_seq[i]);
        end
        bus.Din_valid = 1'b0;
        check("s_done_edges", edges, 8);
        check("s_done", bus.Done, 1'b1);
        check("s_pass", bus.Pass, 1'b1);

        // Reset mid-run after two samples, then a clean run from IDLE
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.Din       = din_seq[i];
            bus.Din_valid = 1'b1;
            tick();
        end
        bus.Din_valid = 1'b0;
        check("r_partial_sig", bus.Signature, 8'h1D);
        #3 rst_n = 1'b0;
        #1;
        check("r_sig", bus.Signature, 8'h00);
        check("r_busy", bus.Busy, 1'b0);
        check("r_done", bus.Done, 1'b0);
        check("r_pass", bus.Pass, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("r_idle_busy", bus.Busy, 1'b0);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("r_load", bus.Load, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.Din       = din_seq[i];
            bus.Din_valid = 1'b1;
            tick();
        end
        bus.Din_valid = 1'b0;
        edges = 0;
        while (bus.Done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        check("r_done_reached", bus.Done, 1'b1);
        check("r_sig_final", bus.Signature, 8'h74);
        check("r_pass_final", bus.Pass, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
